pulse_capture: RTL and testbench

- Downstream measurement stage for the pulse generator: samples the generated pulse train on its logic-analyzer output bit.
- Measures high width and period in clock cycles and pushes one {width, period} record per completed period into a show-ahead FIFO.
- The FIFO is drained by LA/Wishbone glue for readback.

---
 rtl/pulse_capture.sv | 185 ++++++++++++++++++
 tb/tb_pulse_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_capture.sv
// Pulse train capture: measures high width and period per period and queues {width, period} records in a show-ahead FIFO.
// Optional build macro PULSE_CAPTURE_SYNC_EN adds a 2-flop input synchronizer ahead of edge detection.
module pulse_capture #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     pulse_i,
  input  logic                     cap_rd_i,
  output logic [2*CNT_W-1:0]       cap_data_o,
  output logic                     cap_empty_o,
  output logic                     cap_full_o,
  output logic [$clog2(DEPTH):0]   cap_level_o,
  output logic                     cap_ovf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic p;
  logic p_q;
  logic rise;
  logic fall;

`ifdef PULSE_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) sync_q <= '0;
    else          sync_q <= {sync_q[0], pulse_i};
  end

  assign p = sync_q[1];
`else
  assign p = pulse_i;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) p_q <= 1'b0;
    else          p_q <= p;
  end

  assign rise = p & ~p_q;
  assign fall = ~p & p_q;

  // Measurement FSM and counters
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_width_q, hi_width_d;
  logic             push;
  rec_t             push_rec;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      hi_width_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_cnt_q   <= hi_cnt_d;
      per_cnt_q  <= per_cnt_d;
      hi_width_q <= hi_width_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    per_cnt_d  = per_cnt_q;
    hi_width_d = hi_width_q;
    push       = 1'b0;
    if (!en_i) begin
      state_d    = IDLE;
      hi_cnt_d   = '0;
      per_cnt_d  = '0;
      hi_width_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d   = HIGH;
            hi_cnt_d  = CNT_W'(1);
            per_cnt_d = CNT_W'(1);
          end
        end
        HIGH: begin
          hi_cnt_d  = sat_inc(hi_cnt_q);
          per_cnt_d = sat_inc(per_cnt_q);
          if (fall) begin
            hi_width_d = hi_cnt_q;
            state_d    = LOW;
          end
        end
        LOW: begin
          per_cnt_d = sat_inc(per_cnt_q);
          if (rise) begin
            push      = 1'b1;
            hi_cnt_d  = CNT_W'(1);
            per_cnt_d = CNT_W'(1);
            state_d   = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_rec = '{width: hi_width_q, period: per_cnt_q};

  // Record FIFO with registered show-ahead head
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_d;
  logic             ovf_d;
  rec_t             data_d;
  logic             wr_en;
  logic             pop_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = cap_level_o;
    ovf_d    = cap_ovf_o;
    data_d   = cap_data_o;
    wr_en    = 1'b0;
    pop_ok   = cap_rd_i & ~cap_empty_o;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      data_d   = '0;
    end else begin
      wr_en = push & (~cap_full_o | pop_ok);
      if (push && cap_full_o && !pop_ok) ovf_d = 1'b1;
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = cap_level_o + LVL_W'(wr_en) - LVL_W'(pop_ok);
      // Bypass the write when it lands on the slot becoming the head
      data_d  = (wr_en && (wr_ptr_q == rd_ptr_d)) ? push_rec : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cap_level_o <= '0;
      cap_empty_o <= 1'b1;
      cap_full_o  <= 1'b0;
      cap_ovf_o   <= 1'b0;
      cap_data_o  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cap_level_o <= level_d;
      cap_empty_o <= (level_d == '0);
      cap_full_o  <= (level_d == LVL_W'(DEPTH));
      cap_ovf_o   <= ovf_d;
      cap_data_o  <= data_d;
    end
  end

endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: a cycle-stamped reference model queues expected records,
// a negedge monitor checks FIFO status every cycle and each popped head record.
module tb_pulse_capture;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned REC_W = 2 * CNT_W;
  localparam int          SAT   = (1 << CNT_W) - 1;
`ifdef PULSE_CAPTURE_SYNC_EN
  localparam int          SYNC_DLY = 2;
`else
  localparam int          SYNC_DLY = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             pulse = 1'b0;
  logic             rd = 1'b0;
  logic [REC_W-1:0] cap_data;
  logic             cap_empty;
  logic             cap_full;
  logic [LVL_W-1:0] cap_level;
  logic             cap_ovf;

  pulse_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .en_i        (en),
    .clr_i       (clr),
    .pulse_i     (pulse),
    .cap_rd_i    (rd),
    .cap_data_o  (cap_data),
    .cap_empty_o (cap_empty),
    .cap_full_o  (cap_full),
    .cap_level_o (cap_level),
    .cap_ovf_o   (cap_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > SAT) ? CNT_W'(SAT) : CNT_W'(v);
  endfunction

  // Reference model: records from rise/fall timestamps, FIFO as an occupancy count plus queue
  logic [REC_W-1:0] exp_q[$];
  int  cyc = 0;
  int  rise_cyc = 0;
  int  fall_cyc = 0;
  bit  have_rise = 1'b0;
  bit  pq = 1'b0;
  bit [1:0] sh = 2'b00;
  int  m_cnt = 0;
  bit  m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; have_rise = 1'b0; pq = 1'b0; sh = 2'b00;
      m_cnt = 0; m_ovf = 1'b0; exp_q.delete();
    end else begin
      bit p;
      bit mpush;
      bit pop_ok;
      logic [REC_W-1:0] rec;
      p = (SYNC_DLY == 0) ? pulse : sh[1];
      sh = {sh[0], pulse};
      mpush = 1'b0;
      rec = '0;
      if (!en) begin
        have_rise = 1'b0;
      end else begin
        if (p && !pq) begin
          if (have_rise) begin
            mpush = 1'b1;
            rec = {sat(fall_cyc - rise_cyc), sat(cyc - rise_cyc)};
          end
          have_rise = 1'b1;
          rise_cyc = cyc;
        end
        if (!p && pq) fall_cyc = cyc;
      end
      pq = p;
      pop_ok = rd && (m_cnt > 0);
      if (clr) begin
        m_cnt = 0; m_ovf = 1'b0; exp_q.delete();
      end else begin
        if (mpush) begin
          if (m_cnt < DEPTH || pop_ok) begin
            exp_q.push_back(rec);
            m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (pop_ok) m_cnt--;
      end
      cyc++;
    end
  end

  // Monitor: status every cycle, head record on each accepted pop
  always @(negedge clk) begin
    if (!rst) begin
      chk("level", REC_W'(cap_level), REC_W'(m_cnt));
      chk("empty", REC_W'(cap_empty), REC_W'(m_cnt == 0));
      chk("full",  REC_W'(cap_full),  REC_W'(m_cnt == DEPTH));
      chk("ovf",   REC_W'(cap_ovf),   REC_W'(m_ovf));
      if (rd && !cap_empty) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL head: got %h expected no record at %0t", cap_data, $time);
        end else begin
          chk("head", cap_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic train(input int hi, input int lo, input int n);
    repeat (n) begin
      pulse = 1'b1; repeat (hi) tick();
      pulse = 1'b0; repeat (lo) tick();
    end
  endtask

  task automatic restart();
    en = 1'b0; pulse = 1'b0; rd = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    repeat (SYNC_DLY + 1) tick();
  endtask

  task automatic drain(input logic [REC_W-1:0] exp, input bit use_exp);
    int guard;
    guard = 0;
    while (!cap_empty && guard < 2 * DEPTH) begin
      if (use_exp) chk("drain_data", cap_data, exp);
      rd = 1'b1;
      tick();
      guard++;
    end
    rd = 1'b0;
    if (guard >= 2 * DEPTH) begin
      n_chk++;
      $display("FAIL drain_timeout: level %0d still not empty", cap_level);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},  cap_data, '0);
    chk({tag, "_empty"}, REC_W'(cap_empty), REC_W'(1));
    chk({tag, "_full"},  REC_W'(cap_full), '0);
    chk({tag, "_level"}, REC_W'(cap_level), '0);
    chk({tag, "_ovf"},   REC_W'(cap_ovf), '0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst");
    #20 rst = 1'b0;
    tick();

    // Periodic 3/5 train: first rise yields nothing
    restart();
    train(3, 5, 4);
    repeat (SYNC_DLY) tick();
    chk("t1_level", REC_W'(cap_level), REC_W'(3));
    drain(32'h0003_0008, 1'b1);

    // Overfill with 2/2 periods
    restart();
    train(2, 2, 10);
    repeat (SYNC_DLY) tick();
    chk("t2_full",  REC_W'(cap_full), REC_W'(1));
    chk("t2_level", REC_W'(cap_level), REC_W'(8));
    chk("t2_ovf",   REC_W'(cap_ovf), REC_W'(1));
    drain(32'h0002_0004, 1'b1);

    // Push and pop together at full
    restart();
    train(2, 2, 9);
    repeat (SYNC_DLY) tick();
    chk("t3_full_pre", REC_W'(cap_full), REC_W'(1));
    pulse = 1'b1;
    repeat (SYNC_DLY) tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("t3_level", REC_W'(cap_level), REC_W'(8));
    chk("t3_ovf",   REC_W'(cap_ovf), '0);
    chk("t3_full",  REC_W'(cap_full), REC_W'(1));
    pulse = 1'b0;
    repeat (4) tick();
    drain('0, 1'b0);

    // Saturation of both counters
    restart();
    pulse = 1'b1; repeat (66000) tick();
    pulse = 1'b0; repeat (4) tick();
    pulse = 1'b1; repeat (SYNC_DLY + 1) tick();
    chk("t4_level", REC_W'(cap_level), REC_W'(1));
    chk("t4_data",  cap_data, 32'hFFFF_FFFF);
    pulse = 1'b0; tick();
    drain('0, 1'b0);

    // Enable dropped while high
    restart();
    pulse = 1'b1; repeat (3) tick();
    en = 1'b0; repeat (2) tick();
    en = 1'b1; repeat (2) tick();
    pulse = 1'b0; repeat (3) tick();
    pulse = 1'b1; repeat (4) tick();
    chk("t5_level_a", REC_W'(cap_level), '0);
    pulse = 1'b0; repeat (4) tick();
    pulse = 1'b1; repeat (SYNC_DLY + 1) tick();
    chk("t5_level_b", REC_W'(cap_level), REC_W'(1));
    chk("t5_data",    cap_data, 32'h0004_0008);
    pulse = 1'b0; tick();
    drain('0, 1'b0);

    // Async reset mid-period with two records stored
    restart();
    train(3, 5, 3);
    repeat (SYNC_DLY) tick();
    chk("t6_level_pre", REC_W'(cap_level), REC_W'(2));
    pulse = 1'b1; tick(); tick();
    #1 rst = 1'b1;
    #1 chk_reset_vals("t6");
    pulse = 1'b0;
    #2 rst = 1'b0;
    tick();
    train(3, 5, 3);
    repeat (SYNC_DLY) tick();
    chk("t6_level_post", REC_W'(cap_level), REC_W'(2));
    drain(32'h0003_0008, 1'b1);

    // Randomized traffic
    restart();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) pulse = ~pulse;
      en  = ($urandom_range(0, 49) != 0);
      rd  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    en = 1'b0; clr = 1'b0; rd = 1'b0; pulse = 1'b0;
    tick();
    drain('0, 1'b0);
    tick();
    chk("final_queue", REC_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
